serial_tx_arbiter: RTL and testbench
====================================

// Module: serial_tx_arbiter
// PURPOSE
//  Shares the single serial_tx byte transmitter between NUM_REQ byte-stream requesters.
//  Example requesters: the RX echo path and the particle-filter result streamer.
//  Packet-granular round-robin: a granted requester keeps the transmitter until it sends a byte flagged last.
//  Sits between the requesters and serial_tx: drives i_Tx_DV/i_Tx_Byte and consumes o_Tx_Done.
// PARAMETERS
//  NUM_REQ        2     number of requesters (>=2)
//  TIMEOUT_CYCLES 48000 clocks a granted requester may stall between bytes before forced release; 0 = never
// PORTS
//  i_Clock      in   1          system clock (48 MHz HFOSC); single clock domain
//  i_Reset      in   1          asynchronous, active-high reset
//  i_Req_Valid  in   NUM_REQ    requester r has a byte on i_Req_Byte[8r+:8]
//  i_Req_Byte   in   8*NUM_REQ  packed request bytes
//  i_Req_Last   in   NUM_REQ    byte is the last byte of the packet
//  o_Req_Ready  out  NUM_REQ    one-cycle consume strobe; byte was taken
//  o_Grant      out  NUM_REQ    one-hot current owner; all-zero when idle
//  o_Tx_DV      out  1          one-cycle launch strobe to serial_tx
//  o_Tx_Byte    out  8          byte to serial_tx
//  i_Tx_Done    in   1          serial_tx end-of-stop-bit pulse
//  o_Busy       out  1          grant held (state != S_IDLE)
//  o_Timeout    out  1          one-cycle pulse on forced release
// BEHAVIOUR
//  Reset: all outputs 0; state S_IDLE; last_grant = NUM_REQ-1 so requester 0 wins first; timeout count 0.
//  All outputs are registered.
//  S_IDLE:
//   - If any i_Req_Valid is high, pick the first valid index after last_grant, cyclically.
//   - Register o_Grant one-hot and go to S_LAUNCH.
//   - No valid: stay.
//  S_LAUNCH (g = granted index):
//   - If i_Req_Valid[g] is high, at the next edge: o_Tx_DV=1, o_Tx_Byte=i_Req_Byte[g], o_Req_Ready[g]=1.
//     All three are high for exactly one cycle. Latch i_Req_Last[g]; clear the timeout count; go to S_WAIT.
//   - Otherwise increment the timeout count. When it reaches TIMEOUT_CYCLES (nonzero):
//     pulse o_Timeout, clear o_Grant, last_grant=g, go to S_IDLE.
//  S_WAIT:
//   - Hold o_Grant and ignore requester inputs until i_Tx_Done.
//   - On i_Tx_Done with last latched: clear o_Grant, last_grant=g, go to S_IDLE.
//   - On i_Tx_Done without last: go to S_LAUNCH.
//  Latency:
//   - Valid seen in S_IDLE at cycle N: grant at N+1, o_Tx_DV and o_Req_Ready at N+2.
//   - Back-to-back bytes within a packet: o_Tx_DV one cycle after i_Tx_Done if the next byte is already valid.
//  Requester rule: hold valid/byte/last stable until o_Req_Ready is seen; may change them the cycle after.
//  Non-granted requesters never see o_Req_Ready. Only the grant holder's inputs are sampled.
//  i_Tx_Done in S_IDLE or S_LAUNCH: ignored.
//  Done coinciding with other requesters' valid: release first, re-arbitrate in S_IDLE the next cycle.
//   - No same-cycle handover. Minimum one idle cycle between packets.
//  Valid withdrawn by the grant holder in S_LAUNCH: treated as a stall and counts toward the timeout.
//  Reset mid-packet: immediate return to reset values. A byte already launched in serial_tx is not cancelled.
//  Timeout count width: $clog2(TIMEOUT_CYCLES+1). Saturates; never wraps.
//  last_grant update ensures a timed-out requester loses priority to all others for one round.
// STRUCTURE
//  Package serial_arb_pkg:
//   - state localparams S_IDLE / S_LAUNCH / S_WAIT (2-bit)
//   - BYTE_W = 8
//  Sub-module rr_picker: combinational round-robin selector.
//   - Inputs: req vector, last_grant index. Outputs: one-hot pick, index, any.
//   - Parameterised by NUM_REQ.
//  Top: FSM, grant/last registers, timeout counter, output registers, byte mux.
// TESTING (bench models serial_tx: i_Tx_Done pulses 520 cycles after o_Tx_DV at 921600 baud)
//  1. Single requester
//   - Stimulus: req0 sends 0x41 (last=1).
//   - Response: o_Grant=01 at N+1; o_Tx_DV and o_Req_Ready[0] at N+2 with o_Tx_Byte=0x41;
//     o_Busy drops the cycle after Done.
//  2. Packet holding
//   - Stimulus: req0 sends 3-byte packet 0x10,0x11,0x12 (last on 0x12) while req1 holds 0xAA valid throughout.
//   - Response: serial order 10,11,12,AA; o_Grant never changes mid-packet.
//  3. Round-robin fairness
//   - Stimulus: both requesters continuously send 1-byte packets (req0=0x01, req1=0x02) for 6 packets.
//   - Response: alternating 01,02,01,02,01,02 starting with req0 after reset.
//  4. Timeout
//   - Stimulus: TIMEOUT_CYCLES=16; req1 sends byte 0x55 last=0, then drops valid.
//   - Response: o_Timeout pulses 16 cycles into S_LAUNCH; grant cleared; pending req0 byte served next.
//  5. Reset mid-packet
//   - Stimulus: assert i_Reset during S_WAIT of byte 2 of 3.
//   - Response: all outputs 0 asynchronously; after release, req0 has priority; no spurious o_Tx_DV.
//  6. Stray Done
//   - Stimulus: pulse i_Tx_Done in S_IDLE and in S_LAUNCH.
//   - Response: no state change, no o_Req_Ready, no o_Tx_DV.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared FSM state encoding and byte width for the serial_tx arbiter
package serial_arb_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector, first set request after last_i (cyclic)
//  req_i  in  NUM_REQ  request vector
//  last_i in  IW       index granted most recently
//  pick_o out NUM_REQ  one-hot winner
//  idx_o  out IW       winner index
//  any_o  out 1        at least one request set
module rr_picker #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest requester after last_i wins.
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    j      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % NUM_REQ);
      if (req_i[j]) begin
        pick_o    = '0;
        pick_o[j] = 1'b1;
        idx_o     = j;
        any_o     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: packet-granular round-robin sharing of one serial_tx among NUM_REQ byte streams
//  i_Clock/i_Reset                        clock, async active-high reset
//  i_Req_Valid/i_Req_Byte/i_Req_Last      per-requester byte stream (byte r at [8r+:8])
//  o_Req_Ready                            one-cycle consume strobe to the grant holder
//  o_Grant                                one-hot owner, zero when idle
//  o_Tx_DV/o_Tx_Byte, i_Tx_Done           serial_tx launch and completion handshake
//  o_Busy, o_Timeout                      grant held; one-cycle forced-release pulse
module serial_tx_arbiter
  import serial_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int TIMEOUT_CYCLES = 48000,
  localparam int IW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW             = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic [NUM_REQ-1:0]        i_Req_Valid,
  input  logic [BYTE_W*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]        i_Req_Last,
  output logic [NUM_REQ-1:0]        o_Req_Ready,
  output logic [NUM_REQ-1:0]        o_Grant,
  output logic                      o_Tx_DV,
  output logic [BYTE_W-1:0]         o_Tx_Byte,
  input  logic                      i_Tx_Done,
  output logic                      o_Busy,
  output logic                      o_Timeout
);
  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q, ready_q, pick;
  logic [IW-1:0]       idx_q, last_q, pick_idx;
  logic                pick_any, pkt_last_q, tx_dv_q, busy_q, timeout_q, expire;
  logic [BYTE_W-1:0]   tx_byte_q;
  logic [CW-1:0]       cnt_q, cnt_d;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (i_Req_Valid),
    .last_i(last_q),
    .pick_o(pick),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign cnt_d  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign expire = (TIMEOUT_CYCLES != 0) && (cnt_d == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      idx_q      <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      pkt_last_q <= 1'b0;
      cnt_q      <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      ready_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_dv_q   <= 1'b0;
      ready_q   <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: if (pick_any) begin
          grant_q <= pick;
          idx_q   <= pick_idx;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_LAUNCH;
        end
        S_LAUNCH: if (i_Req_Valid[idx_q]) begin
          tx_dv_q    <= 1'b1;
          tx_byte_q  <= i_Req_Byte[BYTE_W*idx_q +: BYTE_W];
          ready_q    <= grant_q;
          pkt_last_q <= i_Req_Last[idx_q];
          cnt_q      <= '0;
          state_q    <= S_WAIT;
        end else if (expire) begin
          // Releasing with last_q = idx_q puts the stalled requester behind everyone else.
          timeout_q <= 1'b1;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          last_q    <= idx_q;
          cnt_q     <= '0;
          state_q   <= S_IDLE;
        end else begin
          cnt_q <= cnt_d;
        end
        S_WAIT: if (i_Tx_Done) begin
          if (pkt_last_q) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= idx_q;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_LAUNCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;
  assign o_Busy      = busy_q;
  assign o_Timeout   = timeout_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench with a packet-level round-robin reference model
module tb_serial_tx_arbiter;
  localparam int N   = 2;
  localparam int TO  = 16;
  localparam int TXD = 520;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   vld = '0, lst = '0;
  logic [8*N-1:0] byt = '0;
  logic           done_m = 1'b0, stray = 1'b0;
  logic [N-1:0]   rdy, gnt;
  logic           dv, busy, tmo;
  logic [7:0]     txb;

  serial_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Req_Valid(vld),
    .i_Req_Byte (byt),
    .i_Req_Last (lst),
    .o_Req_Ready(rdy),
    .o_Grant    (gnt),
    .o_Tx_DV    (dv),
    .o_Tx_Byte  (txb),
    .i_Tx_Done  (done_m | stray),
    .o_Busy     (busy),
    .o_Timeout  (tmo)
  );

  int total = 0, bad = 0, tmo_seen = 0, tx_cnt = 0;
  logic [8:0] q0[$], q1[$], s0[$], s1[$];
  logic [8:0] exp_q[$];
  logic [8:0] e;
  logic [N-1:0] pg = '0;
  logic pb = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic stage(input int r, input logic [8:0] v);
    if (r == 0) s0.push_back(v); else s1.push_back(v);
  endtask

  // Reference: whole packets granted round-robin among requesters with queued data.
  task automatic commit();
    logic [8:0] a0[$];
    logic [8:0] a1[$];
    logic [8:0] w;
    int last, r, c;
    a0 = s0;
    a1 = s1;
    last = N - 1;
    while (a0.size() + a1.size() > 0) begin
      r = 0;
      for (int k = N; k >= 1; k--) begin
        c = (last + k) % N;
        if ((c == 0 && a0.size() > 0) || (c == 1 && a1.size() > 0)) r = c;
      end
      w = 9'h100;
      do begin
        if (r == 0) w = a0.pop_front(); else w = a1.pop_front();
        exp_q.push_back({r[0], w[7:0]});
        if (r == 0) q0.push_back(w); else q1.push_back(w);
      end while (!w[8]);
      last = r;
    end
    s0.delete();
    s1.delete();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", gnt, 0);
    chk("rst_dv", dv, 0);
    chk("rst_ready", rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_byte", txb, 0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", n < bound, 1);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done_m && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done_m, 1);
  endtask

  // Requesters: present queue head, drop it once its ready strobe has been seen.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy[0] && q0.size() > 0) void'(q0.pop_front());
    if (rdy[1] && q1.size() > 0) void'(q1.pop_front());
    vld[0] = q0.size() > 0;
    vld[1] = q1.size() > 0;
    {lst[0], byt[7:0]}  = (q0.size() > 0) ? q0[0] : 9'h0;
    {lst[1], byt[15:8]} = (q1.size() > 0) ? q1[0] : 9'h0;
  end

  // serial_tx model: Done pulses TXD cycles after each launch; reset does not cancel it.
  initial forever begin
    @(posedge clk);
    #1;
    done_m = 1'b0;
    if (dv && !rst) tx_cnt = TXD;
    else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) done_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pb = 1'b0;
    end else begin
      if (dv) begin
        if (exp_q.size() == 0) chk("unexpected_dv", {24'h0, txb}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", txb, e[7:0]);
          chk("req_ready", rdy, 32'(2'b01 << e[8]));
          chk("grant_at_dv", gnt, 32'(2'b01 << e[8]));
        end
      end else if (rdy != '0) chk("ready_without_dv", rdy, 0);
      if (pb && busy) chk("grant_stable", gnt, pg);
      if (tmo) tmo_seen++;
      pg = gnt;
      pb = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, np, len;
    do_reset();

    // single requester, latency and release timing
    @(negedge clk);
    stage(0, 9'h141);
    commit();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t1_grant_n1", gnt, 2'b01);
    chk("t1_no_dv_n1", dv, 0);
    @(negedge clk);
    chk("t1_dv_n2", dv, 1);
    wait_done(TXD + 20);
    chk("t1_busy_before_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_after_done", busy, 0);
    chk("t1_grant_after_done", gnt, 0);

    // packet holding against a waiting requester
    do_reset();
    stage(0, 9'h010); stage(0, 9'h011); stage(0, 9'h112);
    stage(1, 9'h1AA);
    commit();
    drain(5 * (TXD + 10));

    // fairness: alternating single-byte packets
    do_reset();
    for (int i = 0; i < 3; i++) begin
      stage(0, 9'h101);
      stage(1, 9'h102);
    end
    commit();
    drain(7 * (TXD + 10));

    // timeout with a stray Done in S_LAUNCH
    do_reset();
    q1.push_back(9'h055);
    exp_q.push_back({1'b1, 8'h55});
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_first_launch", exp_q.size(), 0);
    q0.push_back(9'h166);
    exp_q.push_back({1'b0, 8'h66});
    wait_done(TXD + 20);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!tmo && n < 40) begin
      @(posedge clk);
      n++;
      #1 stray = (n == 5);
      @(negedge clk);
      if (n == 8) chk("t4_grant_in_launch", gnt, 2'b10);
    end
    stray = 1'b0;
    chk("t4_timeout_cycle", n, TO);
    chk("t4_grant_cleared", gnt, 0);
    chk("t4_busy_cleared", busy, 0);
    @(negedge clk);
    chk("t4_timeout_one_cycle", tmo, 0);
    drain(2 * (TXD + 10));

    // stray Done while idle
    repeat (3) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_grant", gnt, 0);
    end

    // reset during the wait for byte 2 of 3
    q0.push_back(9'h021); q0.push_back(9'h022); q0.push_back(9'h123);
    exp_q.push_back({1'b0, 8'h21});
    exp_q.push_back({1'b0, 8'h22});
    n = 0;
    while (exp_q.size() > 0 && n < 2 * (TXD + 20)) begin
      @(negedge clk);
      n++;
    end
    chk("t5_two_bytes", exp_q.size(), 0);
    repeat (100) @(negedge clk);
    chk("t5_busy_mid", busy, 1);
    do_reset();
    repeat (TXD + 80) @(negedge clk);
    stage(1, 9'h1B1);
    stage(0, 9'h1B0);
    commit();
    drain(3 * (TXD + 10));

    // randomized packet mixes
    for (int round = 0; round < 2; round++) begin
      do_reset();
      for (int r = 0; r < N; r++) begin
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) stage(r, {b == len - 1, 8'($urandom_range(0, 255))});
        end
      end
      commit();
      drain(20 * (TXD + 10));
    end

    chk("timeout_pulses", tmo_seen, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
